// File: rtl/bcd_time_counter_hms_pkg.sv
// Shared types, field offsets, limits and helpers for the HH:MM:SS counter.
// Helpers: bcd_time_valid (preset range check), to_12h (hour display map).
package bcd_time_pkg;

    localparam int S_O = 0;
    localparam int S_T = 4;
    localparam int M_O = 8;
    localparam int M_T = 12;
    localparam int H_O = 16;
    localparam int H_T = 20;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       SEC_T_MAX = 4'd5;
    localparam bcd_t       MIN_T_MAX = 4'd5;
    localparam logic [7:0] HOUR_MAX  = 8'h23;

    typedef struct packed {
        bcd_t h_t;
        bcd_t h_o;
        logic pm;
    } hour12_t;

    function automatic logic bcd_time_valid(input logic [23:0] v);
        bcd_t s_o, s_t, m_o, m_t, h_o, h_t;
        s_o = v[S_O+:4];
        s_t = v[S_T+:4];
        m_o = v[M_O+:4];
        m_t = v[M_T+:4];
        h_o = v[H_O+:4];
        h_t = v[H_T+:4];
        return (s_o <= 4'd9) && (s_t <= SEC_T_MAX) &&
               (m_o <= 4'd9) && (m_t <= MIN_T_MAX) &&
               (h_o <= 4'd9) &&
               ((h_t < 4'd2) || ((h_t == 4'd2) && (h_o <= 4'd3)));
    endfunction

    // Internal hour is always 24h; 00 shows as 12 am, 13..23 as 1..11 pm.
    function automatic hour12_t to_12h(input bcd_t h_t, input bcd_t h_o);
        hour12_t    r;
        logic [4:0] hv;
        hv = 5'(h_t) * 5'd10 + 5'(h_o);
        if (hv == 5'd0) begin
            r = '{h_t: 4'd1, h_o: 4'd2, pm: 1'b0};
        end else if (hv < 5'd12) begin
            r = '{h_t: h_t, h_o: h_o, pm: 1'b0};
        end else if (hv == 5'd12) begin
            r = '{h_t: 4'd1, h_o: 4'd2, pm: 1'b1};
        end else begin
            hv = hv - 5'd12;
            r.pm  = 1'b1;
            r.h_t = (hv >= 5'd10) ? 4'd1 : 4'd0;
            r.h_o = 4'((hv >= 5'd10) ? hv - 5'd10 : hv);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter_hms_if.sv
// Control/status bundle of the time counter.
// master: drives en, mode_12h, load, load_val; slave: drives time and strobes.
interface bcd_time_counter_hms_if;
    logic        en;
    logic        mode_12h;
    logic        load;
    logic [23:0] load_val;
    logic [23:0] time_bcd;
    logic        pm;
    logic        sec_tick;
    logic        min_carry;
    logic        hour_carry;
    logic        day_wrap;
    logic        load_err;

    modport master (
        output en, mode_12h, load, load_val,
        input  time_bcd, pm, sec_tick, min_carry,
        input  hour_carry, day_wrap, load_err
    );

    modport slave (
        input  en, mode_12h, load, load_val,
        output time_bcd, pm, sec_tick, min_carry,
        output hour_carry, day_wrap, load_err
    );
endinterface

// File: rtl/bcd_time_counter_hms_digit.sv
// Single BCD digit counting 0..MAX with load.
// Ports: clk, rst_n, inc, load, ld_val -> q, wrap (combinational inc && q==MAX).
module bcd_digit
    import bcd_time_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic load,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic wrap
);

    assign wrap = inc && (q == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= ld_val;
        end else if (inc) begin
            q <= (q == MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_time_counter_hms.sv
// HH:MM:SS BCD time-of-day counter with prescaler, 12/24h view and preset.
// Ports: clk, rst_n, bus (slave: en/mode_12h/load/load_val in; time/strobes out).
module bcd_time_counter_hms
    import bcd_time_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int DIV_W   = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_time_counter_hms_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic    tick, load_ok, inc;
    bcd_t    s_o, s_t, m_o, m_t, h_o, h_t;
    logic    s_o_wrap, s_t_wrap, m_o_wrap, m_t_wrap;
    logic    day;
    hour12_t h12;

    assign tick    = bus.en && (div_cnt == DIV_LAST);
    assign load_ok = bus.load && bcd_time_valid(bus.load_val);
    // A valid load swallows a coincident tick.
    assign inc     = tick && !load_ok;
    assign day     = m_t_wrap && ({h_t, h_o} == HOUR_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (load_ok) begin
            div_cnt <= '0;
        end else if (bus.en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    bcd_digit #(.MAX(4'd9)) u_s_o (
        .clk(clk), .rst_n(rst_n), .inc(inc), .load(load_ok),
        .ld_val(bus.load_val[S_O+:4]), .q(s_o), .wrap(s_o_wrap)
    );

    bcd_digit #(.MAX(SEC_T_MAX)) u_s_t (
        .clk(clk), .rst_n(rst_n), .inc(s_o_wrap), .load(load_ok),
        .ld_val(bus.load_val[S_T+:4]), .q(s_t), .wrap(s_t_wrap)
    );

    bcd_digit #(.MAX(4'd9)) u_m_o (
        .clk(clk), .rst_n(rst_n), .inc(s_t_wrap), .load(load_ok),
        .ld_val(bus.load_val[M_O+:4]), .q(m_o), .wrap(m_o_wrap)
    );

    bcd_digit #(.MAX(MIN_T_MAX)) u_m_t (
        .clk(clk), .rst_n(rst_n), .inc(m_o_wrap), .load(load_ok),
        .ld_val(bus.load_val[M_T+:4]), .q(m_t), .wrap(m_t_wrap)
    );

    // Hours as one two-digit unit: 09->10, 19->20, 23->00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_t <= '0;
            h_o <= '0;
        end else if (load_ok) begin
            h_t <= bus.load_val[H_T+:4];
            h_o <= bus.load_val[H_O+:4];
        end else if (m_t_wrap) begin
            if (day) begin
                h_t <= '0;
                h_o <= '0;
            end else if (h_o == 4'd9) begin
                h_t <= h_t + 4'd1;
                h_o <= '0;
            end else begin
                h_o <= h_o + 4'd1;
            end
        end
    end

    logic st_r, mc_r, hc_r, dw_r, le_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r <= 1'b0;
            mc_r <= 1'b0;
            hc_r <= 1'b0;
            dw_r <= 1'b0;
            le_r <= 1'b0;
        end else begin
            st_r <= inc;
            mc_r <= s_t_wrap;
            hc_r <= m_t_wrap;
            dw_r <= day;
            le_r <= bus.load && !load_ok;
        end
    end

    assign h12 = to_12h(h_t, h_o);

    assign bus.time_bcd = bus.mode_12h ?
                          {h12.h_t, h12.h_o, m_t, m_o, s_t, s_o} :
                          {h_t, h_o, m_t, m_o, s_t, s_o};
    assign bus.pm         = h12.pm;
    assign bus.sec_tick   = st_r;
    assign bus.min_carry  = mc_r;
    assign bus.hour_carry = hc_r;
    assign bus.day_wrap   = dw_r;
    assign bus.load_err   = le_r;

endmodule

// File: tb/tb_bcd_time_counter_hms.sv
// Scoreboard bench for bcd_time_counter_hms against a seconds-of-day model.
// Driver pushes expected outputs per cycle; a monitor pops and compares.
module tb_bcd_time_counter_hms;

    localparam int CLK_DIV = 4;
    localparam int DAY     = 86400;

    typedef struct packed {
        logic [23:0] t;
        logic        pm;
        logic        st;
        logic        mc;
        logic        hc;
        logic        dw;
        logic        le;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_time_counter_hms_if bus ();

    bcd_time_counter_hms #(.CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tod   = 0;
    int   pre   = 0;

    function automatic logic [23:0] fmt(input int s, input logic m12);
        int h, mi, se, hd;
        h  = s / 3600;
        mi = (s / 60) % 60;
        se = s % 60;
        hd = h;
        if (m12) hd = (h % 12 == 0) ? 12 : h % 12;
        return {4'(hd / 10), 4'(hd % 10), 4'(mi / 10),
                4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    endfunction

    function automatic int dig(input logic [23:0] v, input int i);
        return int'((v >> (4 * i)) & 24'hF);
    endfunction

    function automatic bit valid(input logic [23:0] v);
        for (int i = 0; i < 6; i++)
            if (dig(v, i) > 9) return 0;
        return (dig(v, 1) * 10 + dig(v, 0) < 60) &&
               (dig(v, 3) * 10 + dig(v, 2) < 60) &&
               (dig(v, 5) * 10 + dig(v, 4) < 24);
    endfunction

    function automatic int to_sec(input logic [23:0] v);
        return (dig(v, 5) * 10 + dig(v, 4)) * 3600 +
               (dig(v, 3) * 10 + dig(v, 2)) * 60 +
               dig(v, 1) * 10 + dig(v, 0);
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = {bus.time_bcd, bus.pm, bus.sec_tick, bus.min_carry,
             bus.hour_carry, bus.day_wrap, bus.load_err};
        return a;
    endfunction

    task automatic step(input bit e, input bit m, input bit l,
                        input logic [23:0] lv);
        obs_t o;
        @(negedge clk);
        bus.en       = e;
        bus.mode_12h = m;
        bus.load     = l;
        bus.load_val = lv;
        o = '0;
        if (l && valid(lv)) begin
            tod = to_sec(lv);
            pre = 0;
        end else begin
            o.le = l;
            if (e) begin
                pre++;
                if (pre == CLK_DIV) begin
                    pre  = 0;
                    tod  = (tod + 1) % DAY;
                    o.st = 1'b1;
                    o.mc = (tod % 60 == 0);
                    o.hc = (tod % 3600 == 0);
                    o.dw = (tod == 0);
                end
            end
        end
        o.t  = fmt(tod, m);
        o.pm = (tod >= 43200);
        exp_q.push_back(o);
    endtask

    task automatic idle(input int n, input bit e, input bit m);
        for (int i = 0; i < n; i++) step(e, m, 1'b0, 24'h0);
    endtask

    task automatic chk(input string name, input obs_t got, input obs_t req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    function automatic logic [23:0] rand_valid();
        int h, mi, se;
        h  = int'($urandom_range(0, 23));
        mi = int'($urandom_range(0, 59));
        se = int'($urandom_range(0, 59));
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10),
                4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    endfunction

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scoreboard", sample(), e);
            end
        end
    end

    initial begin : driver
        obs_t z;
        logic [23:0] lv;
        bit          e, m, l;
        bus.en       = 1'b0;
        bus.mode_12h = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        #2;
        z = '0;
        chk("reset_24h", sample(), z);
        bus.mode_12h = 1'b1;
        #1;
        z.t = 24'h120000;
        chk("reset_12h", sample(), z);
        #9;
        rst_n = 1'b1;

        idle(14, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 24'h235958);
        idle(2 * CLK_DIV + 2, 1'b1, 1'b0);

        step(1'b1, 1'b1, 1'b1, 24'h000000);
        step(1'b1, 1'b1, 1'b1, 24'h130507);
        step(1'b1, 1'b1, 1'b1, 24'h115959);
        idle(CLK_DIV + 1, 1'b1, 1'b1);

        step(1'b1, 1'b0, 1'b1, 24'h246000);
        step(1'b1, 1'b0, 1'b1, 24'h006A00);
        step(1'b1, 1'b0, 1'b1, 24'h196000);
        step(1'b0, 1'b0, 1'b1, 24'h240000);

        while (pre != CLK_DIV - 1) step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 1'b1, 24'h101010);
        idle(CLK_DIV + 2, 1'b1, 1'b0);
        idle(20, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 24'h083000);

        for (int i = 0; i < 2000; i++) begin
            e = ($urandom_range(0, 9) < 8);
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 1) == 1) ? rand_valid() : 24'($urandom);
            step(e, m, l, lv);
        end

        step(1'b1, 1'b0, 1'b1, 24'h075959);
        idle(2, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        z   = '0;
        z.t = fmt(0, bus.mode_12h);
        chk("async_reset", sample(), z);
        tod = 0;
        pre = 0;
        #1;
        rst_n = 1'b1;
        idle(2 * CLK_DIV + 1, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            e = ($urandom_range(0, 3) != 0);
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 9) == 0);
            lv = ($urandom_range(0, 1) == 1) ? rand_valid() : 24'($urandom);
            step(e, m, l, lv);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
